uart_cmd_wrapper: RTL

- Byte-to-command assembler between the UART receiver/transmitter and the command processor of the Knight.
- Receive side: takes two consecutive received bytes (high byte first) and presents one 16-bit command with a ready flag.
- Transmit side: accepts single-byte responses (positive ack 0xA5 and similar) from the command processor and sequences them onto the UART transmitter, buffering one pending response while the transmitter is busy.

---
 rtl/uart_cmd_wrapper_pkg.sv | 28 ++
 rtl/resp_tx_queue.sv | 89 ++++++++
 rtl/uart_cmd_wrapper.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_cmd_wrapper_pkg.sv
// Shared constants for the Knight UART command wrapper: FSM state encodings,
// response codes and the default inter-byte timeout.
package uart_cmd_wrapper_pkg;

    localparam logic [0:0] RX_HIGH = 1'b0;
    localparam logic [0:0] RX_LOW  = 1'b1;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_BUSY = 1'b1;

    localparam logic [7:0] POS_ACK = 8'hA5;

    localparam int unsigned CMD_TMO_W = 17;
    localparam logic [16:0] CMD_TMO   = 17'd100000;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } cmd_t;

    function automatic logic [15:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
        cmd_t c;
        c.hi = hi;
        c.lo = lo;
        return c;
    endfunction

endpackage

// File: rtl/resp_tx_queue.sv
// Sequences single-byte responses onto the UART transmitter, holding at most
// one pending response while a byte is in flight.
module resp_tx_queue
    import uart_cmd_wrapper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send_resp,
    input  logic [7:0] resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent
);

    logic [0:0] tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] pend_data_q, pend_data_d;
    logic       pend_valid_q, pend_valid_d;
    logic       trmt_q, trmt_d;
    logic       resp_sent_q, resp_sent_d;

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_data_d    = tx_data_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        trmt_d       = 1'b0;
        resp_sent_d  = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d  = resp;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    if (pend_valid_q) begin
                        tx_data_d    = pend_data_q;
                        trmt_d       = 1'b1;
                        pend_valid_d = 1'b0;
                        // A request landing on the hand-off edge refills the slot just emptied.
                        if (send_resp) begin
                            pend_valid_d = 1'b1;
                            pend_data_d  = resp;
                        end
                    end else if (send_resp) begin
                        tx_data_d = resp;
                        trmt_d    = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else if (send_resp) begin
                    pend_valid_d = 1'b1;
                    pend_data_d  = resp;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // NOTE: the pending byte is reset along with its valid bit so no X can ever reach tx_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_data_q    <= '0;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            trmt_q       <= 1'b0;
            resp_sent_q  <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_data_q    <= tx_data_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            trmt_q       <= trmt_d;
            resp_sent_q  <= resp_sent_d;
        end
    end

    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two UART bytes (high first) into a 16-bit command and forwards
// single-byte responses to the transmitter through resp_tx_queue.
module uart_cmd_wrapper
    import uart_cmd_wrapper_pkg::*;
#(
    parameter int unsigned      TMO_W    = CMD_TMO_W,
    parameter logic [TMO_W-1:0] BYTE_TMO = TMO_W'(CMD_TMO)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        overrun
);

    logic [0:0]       rx_state_q, rx_state_d;
    logic [7:0]       high_q, high_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             clr_rx_rdy_q, clr_rx_rdy_d;
    logic             overrun_q, overrun_d;
    logic             rx_take;

    // rx_rdy is still high in the cycle we acknowledge it, so that cycle is ignored.
    assign rx_take = rx_rdy && !clr_rx_rdy_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        rx_state_d   = rx_state_q;
        high_d       = high_q;
        tmo_d        = tmo_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q && !clr_cmd_rdy;
        clr_rx_rdy_d = 1'b0;
        overrun_d    = 1'b0;

        case (rx_state_q)
            RX_HIGH: begin
                // cmd_rdy is left alone here so an unconsumed command can still be flagged as overrun.
                if (rx_take) begin
                    high_d       = rx_data;
                    tmo_d        = BYTE_TMO;
                    clr_rx_rdy_d = 1'b1;
                    rx_state_d   = RX_LOW;
                end
            end
            RX_LOW: begin
                if (rx_take) begin
                    cmd_d        = join_bytes(high_q, rx_data);
                    cmd_rdy_d    = 1'b1;
                    overrun_d    = cmd_rdy_q && !clr_cmd_rdy;
                    clr_rx_rdy_d = 1'b1;
                    tmo_d        = '0;
                    rx_state_d   = RX_HIGH;
                end else if (tmo_q == '0) begin
                    high_d     = '0;
                    rx_state_d = RX_HIGH;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            default: rx_state_d = RX_HIGH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q   <= RX_HIGH;
            high_q       <= '0;
            tmo_q        <= '0;
            cmd_q        <= '0;
            cmd_rdy_q    <= 1'b0;
            clr_rx_rdy_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            high_q       <= high_d;
            tmo_q        <= tmo_d;
            cmd_q        <= cmd_d;
            cmd_rdy_q    <= cmd_rdy_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign clr_rx_rdy = clr_rx_rdy_q;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign overrun    = overrun_q;

    resp_tx_queue u_resp_tx_queue (
        .clk       (clk),
        .rst       (rst),
        .send_resp (send_resp),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_sent (resp_sent)
    );

endmodule
